// File: rtl/order_book_arbiter.sv
// Round-robin arbiter sharing one order_book between NUM_REQ feed handlers.
// A grant is issued on the book's valid/ready port, then the book's busy period
// (ob_ready low) is tracked until completion. A timeout guards against a hung book.
// Optional feature macro: ARB_DELETE_PRIORITY_EN (delete requests win arbitration).
module order_book_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [32*NUM_REQ-1:0]      req_order_id,
  input  logic [32*NUM_REQ-1:0]      req_quantity,
  input  logic [64*NUM_REQ-1:0]      req_price,
  input  logic [3*NUM_REQ-1:0]       req_type,
  output logic                       ob_valid,
  output logic [31:0]                ob_order_id,
  output logic [31:0]                ob_quantity,
  output logic [63:0]                ob_price,
  output logic [2:0]                 ob_req_type,
  input  logic                       ob_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       done_pulse,
  output logic                       illegal_pulse,
  output logic                       timeout_err,
  input  logic                       err_clear
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GW-1:0] LastIdx = GW'(NUM_REQ - 1);
  localparam logic [CW-1:0] TimeoutLast = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StIssue    = 2'd1;
  localparam logic [1:0] StWaitBusy = 2'd2;
  localparam logic [1:0] StWaitDone = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [GW-1:0]      last_grant_q, last_grant_d;
  logic [GW-1:0]      grant_id_q, grant_id_d;
  logic [31:0]        order_id_q, order_id_d;
  logic [31:0]        quantity_q, quantity_d;
  logic [63:0]        price_q, price_d;
  logic [2:0]         type_q, type_d;
  logic               done_q, done_d;
  logic               illegal_q, illegal_d;
  logic               terr_q, terr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [NUM_REQ-1:0] arb_mask;
  logic [GW-1:0]      cand;
  logic [GW-1:0]      win_idx;
  logic               win_found;
  logic [2:0]         win_type;
  logic               type_legal;
  logic               accept;

`ifdef ARB_DELETE_PRIORITY_EN
  logic [NUM_REQ-1:0] del_mask;

  // Pending deletes form their own class and shadow every other request type.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      del_mask[i] = req_valid[i] && (req_type[3*i +: 3] == 3'b010);
    end
    arb_mask = (|del_mask) ? del_mask : req_valid;
  end
`else
  assign arb_mask = req_valid;
`endif

  // Round-robin search starting one past the last grant, wrapping at NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = last_grant_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == LastIdx) ? '0 : cand + 1'b1;
      if (!win_found && arb_mask[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_type   = req_type[3*win_idx +: 3];
  assign type_legal = (win_type == 3'b100) || (win_type == 3'b010) || (win_type == 3'b001);
  assign accept     = (state_q == StIdle) && win_found;

  // Accept strobe to the winner; held low during reset so outputs read zero.
  always_comb begin
    req_ready = '0;
    if (accept && !reset) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  // Next-state: grant capture, book handshake tracking and timeout supervision.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    order_id_d   = order_id_q;
    quantity_d   = quantity_q;
    price_d      = price_q;
    type_d       = type_q;
    done_d       = 1'b0;
    illegal_d    = 1'b0;
    terr_d       = terr_q;
    cnt_d        = cnt_q;
    if (err_clear) begin
      terr_d = 1'b0;
    end
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          last_grant_d = win_idx;
          grant_id_d   = win_idx;
          order_id_d   = req_order_id[32*win_idx +: 32];
          quantity_d   = req_quantity[32*win_idx +: 32];
          price_d      = req_price[64*win_idx +: 64];
          type_d       = win_type;
          if (type_legal) begin
            state_d = StIssue;
            cnt_d   = '0;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      StIssue: begin
        if (ob_ready) state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (!ob_ready) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (ob_ready) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_q != StIdle) begin
      // Saturate rather than wrap; the timeout normally exits long before.
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      // A timeout overrides completion and any same-cycle err_clear.
      if (cnt_q == TimeoutLast) begin
        state_d = StIdle;
        done_d  = 1'b0;
        terr_d  = 1'b1;
      end
    end
  end

  // State and payload registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= LastIdx;
      grant_id_q   <= '0;
      order_id_q   <= '0;
      quantity_q   <= '0;
      price_q      <= '0;
      type_q       <= '0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      terr_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      order_id_q   <= order_id_d;
      quantity_q   <= quantity_d;
      price_q      <= price_d;
      type_q       <= type_d;
      done_q       <= done_d;
      illegal_q    <= illegal_d;
      terr_q       <= terr_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ob_valid      = (state_q == StIssue);
  assign busy          = (state_q != StIdle);
  assign ob_order_id   = order_id_q;
  assign ob_quantity   = quantity_q;
  assign ob_price      = price_q;
  assign ob_req_type   = type_q;
  assign grant_id      = grant_id_q;
  assign done_pulse    = done_q;
  assign illegal_pulse = illegal_q;
  assign timeout_err   = terr_q;

endmodule

// File: tb/tb_order_book_arbiter.sv
// Bench for order_book_arbiter: directed scenarios plus randomized transactions
// checked against a queue-free round-robin reference model and a scripted book.
module tb_order_book_arbiter;
  localparam int N  = 4;
  localparam int TO = 4096;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_ready;
  logic [32*N-1:0] req_order_id, req_quantity;
  logic [64*N-1:0] req_price;
  logic [3*N-1:0]  req_type;
  logic            ob_valid, ob_ready;
  logic [31:0]     ob_order_id, ob_quantity;
  logic [63:0]     ob_price;
  logic [2:0]      ob_req_type;
  logic [1:0]      grant_id;
  logic            busy, done_pulse, illegal_pulse, timeout_err, err_clear;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_last;

  always #5 clk = ~clk;

  order_book_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_order_id(req_order_id), .req_quantity(req_quantity), .req_price(req_price),
    .req_type(req_type), .ob_valid(ob_valid), .ob_order_id(ob_order_id),
    .ob_quantity(ob_quantity), .ob_price(ob_price), .ob_req_type(ob_req_type),
    .ob_ready(ob_ready), .grant_id(grant_id), .busy(busy), .done_pulse(done_pulse),
    .illegal_pulse(illegal_pulse), .timeout_err(timeout_err), .err_clear(err_clear)
  );

  // Reference: scan requesters in order last+1, last+2, ... (mod N); deletes first if enabled.
  function automatic int model_winner(input logic [N-1:0] v, input logic [3*N-1:0] t,
                                      input int last);
    logic [N-1:0] cls;
    cls = v;
`ifdef ARB_DELETE_PRIORITY_EN
    begin
      logic [N-1:0] del;
      for (int i = 0; i < N; i++) del[i] = v[i] && (t[3*i +: 3] == 3'b010);
      if (del != 0) cls = del;
    end
`else
    if (t == '1) cls = v;
`endif
    for (int k = 1; k <= N; k++) if (cls[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic bit is_legal(input logic [2:0] t);
    return (t == 3'b100) || (t == 3'b010) || (t == 3'b001);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scripted book, entered just after the accept edge: accept, go busy for busy_len
  // cycles, then complete. Returns just after the completion edge.
  task automatic play_book(input int busy_len, output logic vld_after_hs, output int early_done);
    early_done = 0;
    ob_ready = 1'b1;
    tick;
    vld_after_hs = ob_valid;
    ob_ready = 1'b0;
    for (int i = 0; i < busy_len; i++) begin
      tick;
      if (done_pulse) early_done++;
    end
    ob_ready = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = '0; req_type = '0; req_order_id = '0; req_quantity = '0;
    req_price = '0; ob_ready = 1'b1; err_clear = 1'b0;
    #12;
    req_valid = 4'b1111; req_type = {4{3'b100}};
    #1;
    n_checks++;
    if ({req_ready, ob_valid, busy, done_pulse, illegal_pulse, timeout_err, grant_id} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl got ready=%b vld=%b busy=%b done=%b ill=%b terr=%b gid=%0d want 0",
               req_ready, ob_valid, busy, done_pulse, illegal_pulse, timeout_err, grant_id);
    end
    n_checks++;
    if ({ob_order_id, ob_quantity, ob_price, ob_req_type} !== '0) begin
      n_fail++;
      $display("FAIL reset_payload got id=%h q=%h p=%h t=%b want 0", ob_order_id, ob_quantity,
               ob_price, ob_req_type);
    end
    req_valid = '0;
    tick;
    reset = 1'b0;
    exp_last = N - 1;
  endtask

  task automatic test_single;
    logic vld; int early;
    req_valid = 4'b0001; req_type[2:0] = 3'b100; req_price[63:0] = 64'h64;
    req_order_id[31:0] = 32'hA5A5_0001; req_quantity[31:0] = 32'd250;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL single_ready got %b want 0001", req_ready);
    end
    tick;
    req_valid = '0;
    n_checks++;
    if (ob_valid !== 1'b1 || ob_price !== 64'h64 || ob_req_type !== 3'b100 ||
        ob_order_id !== 32'hA5A5_0001 || ob_quantity !== 32'd250 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL single_issue got vld=%b p=%h t=%b id=%h q=%0d gid=%0d want 1 64 100 a5a50001 250 0",
               ob_valid, ob_price, ob_req_type, ob_order_id, ob_quantity, grant_id);
    end
    play_book(2, vld, early);
    n_checks++;
    if (vld !== 1'b0 || early != 0 || done_pulse !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done got vld_after=%b early=%0d done=%b busy=%b want 0 0 1 0",
               vld, early, done_pulse, busy);
    end
    tick;
    n_checks++;
    if (done_pulse !== 1'b0) begin
      n_fail++; $display("FAIL single_pulse_width got done=%b want 0", done_pulse);
    end
    exp_last = 0;
  endtask

  task automatic test_round_robin;
    logic vld; int early;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    req_valid = 4'b1111; req_type = {4{3'b100}};
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++;
      if (req_ready !== 4'(1 << (i % 4))) begin
        n_fail++; $display("FAIL rr_ready[%0d] got %b want %b", i, req_ready, 4'(1 << (i % 4)));
      end
      tick;
      n_checks++;
      if (grant_id !== 2'(i % 4) || ob_valid !== 1'b1) begin
        n_fail++; $display("FAIL rr_grant[%0d] got gid=%0d vld=%b want %0d 1", i, grant_id,
                           ob_valid, i % 4);
      end
      play_book(1 + i % 3, vld, early);
      n_checks++;
      if (done_pulse !== 1'b1 || early != 0) begin
        n_fail++; $display("FAIL rr_done[%0d] got done=%b early=%0d want 1 0", i, done_pulse, early);
      end
    end
    req_valid = '0;
    exp_last = 3;
  endtask

  task automatic test_illegal;
    logic vld; int early;
    req_valid = 4'b0100; req_type[8:6] = 3'b011;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL illegal_ready got %b want 0100", req_ready);
    end
    tick;
    req_valid = '0;
    n_checks++;
    if (illegal_pulse !== 1'b1 || ob_valid !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd2) begin
      n_fail++; $display("FAIL illegal_drop got ill=%b vld=%b busy=%b gid=%0d want 1 0 0 2",
                         illegal_pulse, ob_valid, busy, grant_id);
    end
    tick;
    n_checks++;
    if (illegal_pulse !== 1'b0 || ob_valid !== 1'b0) begin
      n_fail++; $display("FAIL illegal_after got ill=%b vld=%b want 0 0", illegal_pulse, ob_valid);
    end
    req_valid = 4'b1111; req_type = {4{3'b001}};
    #1;
    n_checks++;
    if (req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL illegal_next got %b want 1000", req_ready);
    end
    tick;
    req_valid = '0;
    play_book(1, vld, early);
    exp_last = 3;
  endtask

  task automatic test_timeout(input bit clear_at_expiry);
    int k; bit seen;
    req_valid = 4'b0001; req_type[2:0] = 3'b010;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL timeout_ready got %b want 0001", req_ready);
    end
    tick;
    req_valid = '0;
    exp_last = 0;
    ob_ready = 1'b1;
    tick;
    ob_ready = 1'b0;
    k = 1; seen = 1'b0;
    while (!seen && k < TO + 8) begin
      if (clear_at_expiry && k == TO - 1) err_clear = 1'b1;
      tick;
      k++;
      err_clear = 1'b0;
      if (timeout_err === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (k != TO) begin
      n_fail++; $display("FAIL timeout_cycle(clr=%0d) got %0d want %0d", clear_at_expiry, k, TO);
    end
    n_checks++;
    if (busy !== 1'b0 || ob_valid !== 1'b0 || done_pulse !== 1'b0) begin
      n_fail++; $display("FAIL timeout_idle got busy=%b vld=%b done=%b want 0 0 0", busy,
                         ob_valid, done_pulse);
    end
    ob_ready = 1'b1;
    tick;
    n_checks++;
    if (timeout_err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_sticky got %b want 1", timeout_err);
    end
    err_clear = 1'b1;
    tick;
    err_clear = 1'b0;
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_clear got %b want 0", timeout_err);
    end
  endtask

  task automatic test_reset_mid;
    logic vld; int early;
    req_valid = 4'b0100; req_type[8:6] = 3'b100;
    tick;
    req_valid = '0;
    tick;
    ob_ready = 1'b0;
    tick;
    req_valid = 4'b1111; req_type = {4{3'b100}};
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, ob_valid, busy, done_pulse, illegal_pulse, timeout_err, grant_id} !== '0 ||
        {ob_order_id, ob_quantity, ob_price, ob_req_type} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid got ready=%b vld=%b busy=%b gid=%0d p=%h want all 0", req_ready,
               ob_valid, busy, grant_id, ob_price);
    end
    tick;
    reset = 1'b0;
    ob_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL reset_mid_first got %b want 0001", req_ready);
    end
    tick;
    req_valid = '0;
    play_book(1, vld, early);
    exp_last = 0;
  endtask

  task automatic test_delete_priority;
    logic vld; int early; logic [3:0] want;
    req_valid = 4'b1000; req_type[11:9] = 3'b100;
    tick;
    req_valid = '0;
    play_book(1, vld, early);
    req_valid = 4'b1001; req_type[2:0] = 3'b100; req_type[11:9] = 3'b010;
`ifdef ARB_DELETE_PRIORITY_EN
    want = 4'b1000;
`else
    want = 4'b0001;
`endif
    #1;
    n_checks++;
    if (req_ready !== want) begin
      n_fail++; $display("FAIL del_prio got %b want %b", req_ready, want);
    end
    tick;
    req_valid = '0;
    play_book(1, vld, early);
    exp_last = (want == 4'b1000) ? 3 : 0;
  endtask

  task automatic test_random;
    logic vld; int early; int w; logic [2:0] t; int r;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(0, 7);
        case (r)
          0, 3:    t = 3'b100;
          1, 4:    t = 3'b010;
          2, 5, 6: t = 3'b001;
          default: t = 3'($urandom_range(0, 7));
        endcase
        req_type[3*i +: 3] = t;
        req_order_id[32*i +: 32] = $urandom;
        req_quantity[32*i +: 32] = $urandom;
        req_price[64*i +: 64] = {$urandom, $urandom};
      end
      req_valid = 4'($urandom_range(1, 15));
      w = model_winner(req_valid, req_type, exp_last);
      #1;
      n_checks++;
      if (req_ready !== 4'(1 << w)) begin
        n_fail++; $display("FAIL rand_ready[%0d] got %b want %b", n, req_ready, 4'(1 << w));
      end
      tick;
      req_valid = '0;
      exp_last = w;
      n_checks++;
      if (grant_id !== 2'(w) || ob_order_id !== req_order_id[32*w +: 32] ||
          ob_quantity !== req_quantity[32*w +: 32] || ob_price !== req_price[64*w +: 64] ||
          ob_req_type !== req_type[3*w +: 3]) begin
        n_fail++; $display("FAIL rand_payload[%0d] got gid=%0d id=%h t=%b want %0d %h %b", n,
                           grant_id, ob_order_id, ob_req_type, w, req_order_id[32*w +: 32],
                           req_type[3*w +: 3]);
      end
      if (is_legal(req_type[3*w +: 3])) begin
        n_checks++;
        if (ob_valid !== 1'b1 || illegal_pulse !== 1'b0) begin
          n_fail++; $display("FAIL rand_issue[%0d] got vld=%b ill=%b want 1 0", n, ob_valid,
                             illegal_pulse);
        end
        play_book($urandom_range(1, 3), vld, early);
        n_checks++;
        if (done_pulse !== 1'b1 || early != 0 || vld !== 1'b0) begin
          n_fail++; $display("FAIL rand_done[%0d] got done=%b early=%0d vld=%b want 1 0 0", n,
                             done_pulse, early, vld);
        end
      end else begin
        n_checks++;
        if (ob_valid !== 1'b0 || illegal_pulse !== 1'b1) begin
          n_fail++; $display("FAIL rand_illegal[%0d] got vld=%b ill=%b want 0 1", n, ob_valid,
                             illegal_pulse);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_illegal;
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid;
    test_delete_priority;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
